// File: rtl/vga_zone_painter_if.sv
// Write port of the 160x120 VGA adapter: one pixel (x, y, colour) per cycle when VGA_PLOT is high.
interface vga_zone_painter_if;
   logic [7:0] VGA_X;
   logic [6:0] VGA_Y;
   logic [2:0] VGA_COLOUR;
   logic       VGA_PLOT;

   modport master (output VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT);
   modport slave  (input  VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT);
endinterface

// File: rtl/vga_zone_painter.sv
// Security status screen sequencer: clears the screen on every armed/alarm mode change,
// then repaints each zone box only when its required colour differs from what was drawn.
module vga_zone_painter #(
   parameter int NZONES = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               armed,
   input  logic               alarm,
   input  logic [31:0]        trigger,
   vga_zone_painter_if.master vga,
   output logic               busy
);
   localparam int            IW       = (NZONES > 1) ? $clog2(NZONES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NZONES - 1);

   typedef enum logic [1:0] {S_INIT, S_CLEAR, S_SCAN, S_DRAW} state_e;

   state_e                   state_q, state_d;
   logic [7:0]               x_q, x_d, ox_q, ox_d, bx0;
   logic [6:0]               y_q, y_d, oy_q, oy_d, by0;
   logic [8:0]               pix_q, pix_d;
   logic [IW-1:0]            idx_q, idx_d, next_idx;
   logic [4:0]               zone;
   logic                     armed_q, armed_d, alarm_q, alarm_d;
   logic                     plot_q, plot_d, busy_q, busy_d;
   logic                     mode_chg, enter_clear;
   logic [2:0]               bg_q, bg_d, col_q, col_d, ocol_q, ocol_d, req_col;
   logic [NZONES-1:0][2:0]   shadow_q, shadow_d;
   logic [NZONES-1:0]        valid_q, valid_d;

   // Zone geometry: 8 columns of 20 px, rows of 30 px; box inset (2,3), 16x24
   always_comb begin
      zone     = 5'(idx_q);
      bx0      = 8'(zone[2:0]) * 8'd20 + 8'd2;
      by0      = 7'(zone[4:3]) * 7'd30 + 7'd3;
      req_col  = !armed_q ? 3'b001 : (trigger[zone] ? 3'b110 : 3'b010);
      next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      mode_chg = (armed != armed_q) | (alarm != alarm_q);
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      pix_d       = pix_q;
      idx_d       = idx_q;
      armed_d     = armed_q;
      alarm_d     = alarm_q;
      bg_d        = bg_q;
      col_d       = col_q;
      shadow_d    = shadow_q;
      valid_d     = valid_q;
      ox_d        = ox_q;
      oy_d        = oy_q;
      ocol_d      = ocol_q;
      plot_d      = 1'b0;
      busy_d      = (state_q == S_CLEAR) || (state_q == S_DRAW);
      enter_clear = 1'b0;

      case (state_q)
         S_INIT: enter_clear = 1'b1;

         S_CLEAR: begin
            if (mode_chg) begin
               enter_clear = 1'b1;
            end else begin
               plot_d = 1'b1;
               ox_d   = x_q;
               oy_d   = y_q;
               ocol_d = bg_q;
               if (x_q == 8'd159) begin
                  x_d = 8'd0;
                  if (y_q == 7'd119) begin
                     y_d     = 7'd0;
                     valid_d = '0;
                     idx_d   = '0;
                     state_d = S_SCAN;
                  end else begin
                     y_d = y_q + 7'd1;
                  end
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end

         S_SCAN: begin
            if (mode_chg) begin
               enter_clear = 1'b1;
            end else if (!valid_q[idx_q] || (shadow_q[idx_q] != req_col)) begin
               col_d   = req_col;
               x_d     = bx0;
               y_d     = by0;
               pix_d   = 9'd0;
               state_d = S_DRAW;
            end else begin
               idx_d = next_idx;
            end
         end

         S_DRAW: begin
            // An abort leaves the shadow untouched; the following clear invalidates it anyway
            if (mode_chg) begin
               enter_clear = 1'b1;
            end else begin
               plot_d = 1'b1;
               ox_d   = x_q;
               oy_d   = y_q;
               ocol_d = col_q;
               if (pix_q == 9'd383) begin
                  shadow_d[idx_q] = col_q;
                  valid_d[idx_q]  = 1'b1;
                  idx_d           = next_idx;
                  state_d         = S_SCAN;
               end else begin
                  pix_d = pix_q + 9'd1;
                  if (x_q == bx0 + 8'd15) begin
                     x_d = bx0;
                     y_d = y_q + 7'd1;
                  end else begin
                     x_d = x_q + 8'd1;
                  end
               end
            end
         end

         default: state_d = S_INIT;
      endcase

      // Every path into CLEAR snapshots the mode so the sweep colour stays consistent
      if (enter_clear) begin
         state_d = S_CLEAR;
         x_d     = 8'd0;
         y_d     = 7'd0;
         armed_d = armed;
         alarm_d = alarm;
         bg_d    = alarm ? 3'b100 : 3'b000;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_INIT;
         x_q      <= '0;
         y_q      <= '0;
         pix_q    <= '0;
         idx_q    <= '0;
         armed_q  <= 1'b0;
         alarm_q  <= 1'b0;
         bg_q     <= '0;
         col_q    <= '0;
         shadow_q <= '0;
         valid_q  <= '0;
         ox_q     <= '0;
         oy_q     <= '0;
         ocol_q   <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         pix_q    <= pix_d;
         idx_q    <= idx_d;
         armed_q  <= armed_d;
         alarm_q  <= alarm_d;
         bg_q     <= bg_d;
         col_q    <= col_d;
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         ocol_q   <= ocol_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
      end
   end

   assign vga.VGA_X      = ox_q;
   assign vga.VGA_Y      = oy_q;
   assign vga.VGA_COLOUR = ocol_q;
   assign vga.VGA_PLOT   = plot_q;
   assign busy           = busy_q;
endmodule
